x_conv_accum: RTL and testbench
===============================

X_CONV_ACCUM -- requirements
Module: x_conv_accum

Interface
REQ-001 The block SHALL have input clk: 1 bit, system clock, all state updates on the rising edge.
REQ-002 The block SHALL have input n_rst: 1 bit, asynchronous, active-low reset.
REQ-003 The block SHALL have input calc_enable: 1 bit, start pulse for a convolution; it is the same signal that feeds the upstream operand-select stage.
REQ-004 The block SHALL have input a: 5 bits, two's-complement filter coefficient, range -16..15.
REQ-005 The block SHALL have input b: 5 bits, unsigned zero-extended pixel value, range 0..15.
REQ-006 The block SHALL have input calc_done: 1 bit, end-of-operands strobe from the upstream stage.
REQ-007 The block SHALL have output gx: 12 bits, two's-complement registered convolution sum.
REQ-008 The block SHALL have output gx_mag: 8 bits, unsigned |gx| saturated to 255.
REQ-009 The block SHALL have output result_valid: 1 bit, one-cycle pulse marking new gx/gx_mag.
REQ-010 The block SHALL have output term_err: 1 bit, registered with result_valid, high when the term count is not 6.
REQ-011 The block SHALL have output busy: 1 bit, high while in state ACCUM.

Function
REQ-012 The block SHALL implement states IDLE, ACCUM and REPORT.
REQ-013 In IDLE with calc_enable=1, the block SHALL clear acc (13-bit signed) and term_cnt (3-bit), and go to ACCUM.
REQ-014 In IDLE with calc_enable=0, the block SHALL ignore a, b and calc_done and hold acc.
REQ-015 In ACCUM with calc_done=0, the block SHALL set acc <= acc + signed(a)*signed({0,b}) and term_cnt <= min(term_cnt+1, 7).
REQ-016 The product SHALL be a 10-bit signed value and SHALL be sign-extended before the add; acc SHALL never wrap, since the worst case over 7 terms is -1680..1575.
REQ-017 In ACCUM with calc_done=1, the block SHALL NOT accumulate that cycle's operands, SHALL register the result, and SHALL go to REPORT.
REQ-018 Registering the result SHALL mean: gx <= acc clamped to -2048..2047; gx_mag <= min(|acc|, 255); term_err <= (term_cnt != 6).
REQ-019 In REPORT, result_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-020 If calc_enable=1 while in REPORT, the block SHALL clear acc and term_cnt and go directly to ACCUM; the pulse in REPORT SHALL still occur.
REQ-021 The latency SHALL be fixed: result_valid is high in the cycle after calc_done is sampled high.
REQ-022 If calc_enable=1 while in ACCUM and calc_done=0, the block SHALL restart: acc and term_cnt are cleared, the state stays ACCUM, that cycle's operands are discarded, and no result is produced.
REQ-023 If calc_enable=1 and calc_done=1 in the same ACCUM cycle, calc_done SHALL take priority: the result is registered, the state goes to REPORT, and the calc_enable is dropped.
REQ-024 Timeout: if term_cnt=7 and calc_done=0 in ACCUM, the block SHALL register the result with term_err=1, go to REPORT, and pulse result_valid.
REQ-025 gx, gx_mag and term_err SHALL hold their values until the next registered result.
REQ-026 busy SHALL be combinationally equal to (state == ACCUM).

Reset
REQ-027 When n_rst=0, the block SHALL asynchronously force state=IDLE, acc=0, term_cnt=0, gx=0, gx_mag=0, result_valid=0 and term_err=0.
REQ-028 A reset during ACCUM or REPORT SHALL discard the partial sum, and no result_valid SHALL follow reset release.
REQ-029 The first calc_enable sampled after reset release SHALL be honoured.

Verification
REQ-030 The bench SHALL cover the nominal Sobel-x case: calc_enable, then a=-1,-2,-1,1,2,1 with b=0,0,0,15,15,15, then calc_done -> next cycle result_valid=1, gx=60, gx_mag=60, term_err=0.
REQ-031 The bench SHALL cover a negative sum with saturation: a=-16 x6, b=15 x6 -> gx=-1440 (0xA60), gx_mag=255, term_err=0.
REQ-032 The bench SHALL cover a positive sum with saturation: a=15 x6, b=15 x6 -> gx=1350, gx_mag=255; a flat image (b=15 all, Sobel-x a) -> gx=0, gx_mag=0.
REQ-033 The bench SHALL cover a short sequence: calc_done after 3 terms (a=1, b=4) -> gx=12, term_err=1.
REQ-034 The bench SHALL cover the timeout: 7 terms of a=1, b=1 with no calc_done -> gx=7, term_err=1, and result_valid 1 cycle later.
REQ-035 The bench SHALL cover restart and reset: a restart after 2 terms followed by a nominal run -> gx=60 with no prior result_valid; n_rst asserted after 4 terms -> all outputs 0 and no result_valid after release.

Source files
------------

// File: rtl/x_conv_accum.sv
// Streaming multiply-accumulate for one 6-tap convolution window: sums a*b over the
// operands presented between calc_enable and calc_done, then reports a clamped result.
module x_conv_accum (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        calc_enable,
    input  logic [4:0]  a,
    input  logic [4:0]  b,
    input  logic        calc_done,
    output logic [11:0] gx,
    output logic [7:0]  gx_mag,
    output logic        result_valid,
    output logic        term_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [12:0] acc;
    logic [2:0]         term_cnt;

    logic clear;
    logic accumulate;
    logic register_result;

    logic signed [10:0] product;
    logic signed [12:0] sum_next;
    logic signed [12:0] abs_acc;
    logic [11:0]        gx_clamped;
    logic [7:0]         mag_sat;

    // Priority inside ACCUM: calc_done, then the 7-term timeout, then restart, then accumulate.
    always_comb begin
        next_state      = state;
        clear           = 1'b0;
        accumulate      = 1'b0;
        register_result = 1'b0;
        unique case (state)
            IDLE: begin
                if (calc_enable) begin
                    clear      = 1'b1;
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (calc_done || (term_cnt == 3'd7)) begin
                    register_result = 1'b1;
                    next_state      = REPORT;
                end else if (calc_enable) begin
                    clear = 1'b1;
                end else begin
                    accumulate = 1'b1;
                end
            end
            REPORT: begin
                if (calc_enable) begin
                    clear      = 1'b1;
                    next_state = ACCUM;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // b is a zero-extended pixel, so it is multiplied as a non-negative signed value.
    assign product  = $signed(a) * $signed({1'b0, b});
    assign sum_next = acc + {{2{product[10]}}, product};

    always_comb begin
        abs_acc = acc[12] ? -acc : acc;
        if (abs_acc > 13'sd255) begin
            mag_sat = 8'hFF;
        end else begin
            mag_sat = abs_acc[7:0];
        end
        if (acc > 13'sd2047) begin
            gx_clamped = 12'h7FF;
        end else if (acc < -13'sd2048) begin
            gx_clamped = 12'h800;
        end else begin
            gx_clamped = acc[11:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc      <= '0;
            term_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            term_cnt <= '0;
        end else if (accumulate) begin
            acc      <= sum_next;
            term_cnt <= (term_cnt == 3'd7) ? 3'd7 : term_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gx           <= '0;
            gx_mag       <= '0;
            term_err     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= register_result;
            if (register_result) begin
                gx       <= gx_clamped;
                gx_mag   <= mag_sat;
                term_err <= (term_cnt != 3'd6);
            end
        end
    end

    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_x_conv_accum.sv
// Scoreboard bench for x_conv_accum: directed Sobel/saturation/timeout/restart/reset
// scenarios plus randomized windows, checked against an arithmetic reference model.
module tb_x_conv_accum;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        calc_enable = 1'b0;
    logic [4:0]  a = '0;
    logic [4:0]  b = '0;
    logic        calc_done = 1'b0;
    logic [11:0] gx;
    logic [7:0]  gx_mag;
    logic        result_valid;
    logic        term_err;
    logic        busy;

    x_conv_accum dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .calc_enable  (calc_enable),
        .a            (a),
        .b            (b),
        .calc_done    (calc_done),
        .gx           (gx),
        .gx_mag       (gx_mag),
        .result_valid (result_valid),
        .term_err     (term_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gx;
        int mag;
        int err;
    } exp_t;

    exp_t sb[$];
    int   ta[$];
    int   tbv[$];
    int   total = 0;
    int   bad = 0;
    int   last_gx = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain sum of products over the first min(n,7) terms.
    function automatic exp_t model(input int n);
        exp_t e;
        int s = 0;
        int m = (n > 7) ? 7 : n;
        for (int i = 0; i < m; i++) s += ta[i] * tbv[i];
        e.gx  = (s > 2047) ? 2047 : ((s < -2048) ? -2048 : s);
        e.mag = (s < 0) ? -s : s;
        if (e.mag > 255) e.mag = 255;
        e.err = (m != 6) ? 1 : 0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (result_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got gx=%0d expected no result_valid (t=%0t)",
                         int'($signed(gx)), $time);
            end else begin
                e = sb.pop_front();
                check("gx", int'($signed(gx)), e.gx);
                check("gx_mag", int'(gx_mag), e.mag);
                check("term_err", int'(term_err), e.err);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run;
        calc_enable = 1'b1;
        calc_done   = 1'b0;
        tick();
        calc_enable = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            a = 5'(ta[i]);
            b = 5'(tbv[i]);
            tick();
        end
    endtask

    task automatic finish_done;
        calc_done = 1'b1;
        a = 5'($urandom);
        b = 5'($urandom_range(0, 15));
        tick();
        calc_done = 1'b0;
        check("latency_valid", int'(result_valid), 1);
        check("busy_in_report", int'(busy), 0);
    endtask

    // One full window: push expectation, start, feed n terms, then calc_done or timeout.
    task automatic run_window(input int n, input bit use_done);
        exp_t e;
        e = model(n);
        last_gx = e.gx;
        sb.push_back(e);
        start_run();
        feed(n);
        if (use_done) begin
            finish_done();
        end else begin
            check("timeout_not_yet", int'(result_valid), 0);
            tick();
            check("timeout_valid", int'(result_valid), 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_gx", int'(gx), 0);
        check("rst_mag", int'(gx_mag), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_err", int'(term_err), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Nominal Sobel-x, then hold check
        ta = {-1, -2, -1, 1, 2, 1};
        tbv = {0, 0, 0, 15, 15, 15};
        run_window(6, 1'b1);
        idle(3);
        check("hold_gx", int'($signed(gx)), 60);

        // Negative and positive saturation, flat image
        ta = {-16, -16, -16, -16, -16, -16};
        tbv = {15, 15, 15, 15, 15, 15};
        run_window(6, 1'b1);
        idle(1);
        ta = {15, 15, 15, 15, 15, 15};
        run_window(6, 1'b1);
        idle(1);
        ta = {-1, -2, -1, 1, 2, 1};
        run_window(6, 1'b1);
        // Restart straight out of REPORT: short sequence
        ta = {1, 1, 1};
        tbv = {4, 4, 4};
        run_window(3, 1'b1);
        idle(2);

        // Timeout after 7 terms
        ta = {1, 1, 1, 1, 1, 1, 1};
        tbv = {1, 1, 1, 1, 1, 1, 1};
        run_window(7, 1'b0);
        idle(2);

        // Restart after 2 terms, then nominal run
        start_run();
        ta = {7, -9};
        tbv = {11, 13};
        feed(2);
        calc_enable = 1'b1;
        a = 5'd15;
        b = 5'd15;
        tick();
        calc_enable = 1'b0;
        check("busy_after_restart", int'(busy), 1);
        ta = {-1, -2, -1, 1, 2, 1};
        tbv = {0, 0, 0, 15, 15, 15};
        feed(6);
        begin
            exp_t e;
            e = model(6);
            sb.push_back(e);
        end
        finish_done();
        idle(2);

        // Reset during ACCUM after 4 terms
        start_run();
        ta = {5, 6, 7, 8};
        tbv = {9, 10, 11, 12};
        feed(4);
        n_rst = 1'b0;
        #1;
        check("mid_rst_gx", int'(gx), 0);
        check("mid_rst_mag", int'(gx_mag), 0);
        check("mid_rst_valid", int'(result_valid), 0);
        check("mid_rst_err", int'(term_err), 0);
        check("mid_rst_busy", int'(busy), 0);
        idle(2);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", int'(result_valid), 0);
            check("post_rst_busy", int'(busy), 0);
        end

        // First calc_enable after release must be honoured
        n_rst = 1'b0;
        idle(1);
        @(negedge clk);
        n_rst = 1'b1;
        ta = {-1, -2, -1, 1, 2, 1};
        tbv = {0, 0, 0, 15, 15, 15};
        run_window(6, 1'b1);
        idle(1);

        // Randomized windows, including back-to-back restarts from REPORT
        for (int k = 0; k < 30; k++) begin
            int n;
            bit use_done;
            n = int'($urandom_range(0, 7));
            use_done = (n == 7) ? 1'($urandom_range(0, 1)) : 1'b1;
            ta.delete();
            tbv.delete();
            for (int i = 0; i < n; i++) begin
                ta.push_back(int'($urandom_range(0, 31)) - 16);
                tbv.push_back(int'($urandom_range(0, 15)));
            end
            run_window(n, use_done);
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
